// File: rtl/bram_port_client_pkg.sv
// rtl/bram_port_client_pkg.sv - shared types and constants for the BRAM port client (option: BRAM_PORT_CLIENT_WRITE_ACK_EN)
package bram_port_client_pkg;

    // Response buffer capacity; together with the pending flag this bounds occupancy.
    localparam int RESP_BUF_DEPTH = 2;
    localparam int CNT_WIDTH      = $clog2(RESP_BUF_DEPTH + 1);

    // Default geometry of the attached RAM port.
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 8;

    // One request as offered by the streaming client.
    typedef struct packed {
        logic                      we;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] data;
    } req_t;

    // Where the currently offered response comes from.
    typedef enum logic [1:0] {
        RESP_SRC_NONE   = 2'd0,
        RESP_SRC_BYPASS = 2'd1,
        RESP_SRC_BUFFER = 2'd2
    } resp_src_e;

    // A new request fits only if buffered entries plus the in-flight one leave a free slot.
    function automatic logic occ_has_room(input logic [CNT_WIDTH-1:0] count,
                                          input logic                 pending);
        logic [CNT_WIDTH:0] occ;
        occ = {1'b0, count} + {{CNT_WIDTH{1'b0}}, pending};
        return occ < (CNT_WIDTH + 1)'(RESP_BUF_DEPTH);
    endfunction

endpackage

// File: rtl/bram_port_client_resp_buffer.sv
// rtl/bram_port_client_resp_buffer.sv - two-entry in-order response FIFO (bram_resp_buffer)
module bram_resp_buffer
    import bram_port_client_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  enq,
    input  logic [DATA_WIDTH-1:0] enq_data,
    input  logic                  deq,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [CNT_WIDTH-1:0]  count
);

    logic [DATA_WIDTH-1:0] slots [RESP_BUF_DEPTH];
    logic                  head;
    logic                  tail;

    // Pointer and occupancy bookkeeping; a simultaneous enq/deq moves both pointers and keeps count.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= ~tail;
            end
            if (deq) begin
                head <= ~head;
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge CLK) begin
        if (enq) begin
            slots[tail] <= enq_data;
        end
    end

    assign head_data = slots[head];

endmodule

// File: rtl/bram_port_client.sv
// rtl/bram_port_client.sv - request/response front end for one BRAM port (option: BRAM_PORT_CLIENT_WRITE_ACK_EN)
module bram_port_client
    import bram_port_client_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WE,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ_DATA,
    output logic                  RESP_VALID,
    input  logic                  RESP_READY,
    output logic [DATA_WIDTH-1:0] RESP_DATA,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [DATA_WIDTH-1:0] MEM_DI,
    output logic                  MEM_WE,
    input  logic [DATA_WIDTH-1:0] MEM_DO
);

    logic                  pending;
    logic                  req_fire;
    logic                  issue_resp;
    logic [DATA_WIDTH-1:0] pend_data;
    logic [CNT_WIDTH-1:0]  buf_count;
    logic [DATA_WIDTH-1:0] buf_head;
    logic                  buf_enq;
    logic                  buf_deq;
    resp_src_e             resp_src;

    // Readiness looks only at registered state so the client never sees a RESP_READY path.
    assign REQ_READY = occ_has_room(buf_count, pending);
    assign req_fire  = REQ_VALID && REQ_READY;

    assign MEM_ADDR  = REQ_ADDR;
    assign MEM_DI    = REQ_DATA;
    assign MEM_WE    = req_fire && REQ_WE;

`ifdef BRAM_PORT_CLIENT_WRITE_ACK_EN
    logic                  pend_is_write;
    logic [DATA_WIDTH-1:0] ack_data;

    assign issue_resp = req_fire;
    assign pend_data  = pend_is_write ? ack_data : MEM_DO;

    // Remember whether the in-flight response is a write acknowledge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pend_is_write <= 1'b0;
        end else if (req_fire) begin
            pend_is_write <= REQ_WE;
        end
    end

    // Hold the written data so the acknowledge can travel down the read-return path.
    always_ff @(posedge CLK) begin
        if (req_fire && REQ_WE) begin
            ack_data <= REQ_DATA;
        end
    end
`else
    assign issue_resp = req_fire && !REQ_WE;
    assign pend_data  = MEM_DO;
`endif

    // The pending flag marks the single cycle in which the RAM presents read data.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pending <= 1'b0;
        end else begin
            pending <= issue_resp;
        end
    end

    // Older buffered data always wins so responses stay in request order.
    always_comb begin
        resp_src = RESP_SRC_NONE;
        if (buf_count != '0) begin
            resp_src = RESP_SRC_BUFFER;
        end else if (pending) begin
            resp_src = RESP_SRC_BYPASS;
        end
    end

    assign RESP_VALID = (resp_src != RESP_SRC_NONE);
    assign RESP_DATA  = (resp_src == RESP_SRC_BUFFER) ? buf_head : pend_data;

    // RAM data must be caught this cycle unless it leaves directly through the bypass.
    assign buf_enq = pending && !((resp_src == RESP_SRC_BYPASS) && RESP_READY);
    assign buf_deq = (resp_src == RESP_SRC_BUFFER) && RESP_READY;

    bram_resp_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_resp_buffer (
        .CLK       (CLK),
        .RESET     (RESET),
        .enq       (buf_enq),
        .enq_data  (pend_data),
        .deq       (buf_deq),
        .head_data (buf_head),
        .count     (buf_count)
    );

endmodule
